// File: rtl/io_bank.sv
// Memory-mapped I/O register bank: synchronised inputs with sticky rising-edge
// flags, read/write output registers and a maskable registered interrupt.
module io_bank #(
    parameter int               WIDTH       = 16,
    parameter int               N_IN        = 2,
    parameter int               N_OUT       = 3,
    parameter int               SYNC_STAGES = 2,
    parameter int               ADDR_W      = 4,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      address,
    input  logic                   load,
    input  logic [WIDTH-1:0]       data,
    output logic [WIDTH-1:0]       q,
    input  logic [N_IN*WIDTH-1:0]  in_bus,
    output logic [N_OUT*WIDTH-1:0] out_bus,
    output logic                   irq
);

    localparam int E        = 2 * N_IN;
    localparam int IRQ_ADDR = E + N_OUT;
    localparam int ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    typedef logic [N_IN-1:0][WIDTH-1:0]  chan_in_t;
    typedef logic [N_OUT-1:0][WIDTH-1:0] chan_out_t;

    chan_in_t         sync_q [SYNC_STAGES];
    chan_in_t         prev_q;
    chan_in_t         edge_q, edge_d;
    chan_out_t        out_q, out_d;
    logic [N_IN-1:0]  irq_en_q, irq_en_d;
    logic [ARM_W-1:0] arm_q;
    logic             irq_q, irq_d;
    chan_in_t         in_val;
    logic             armed;

    assign in_val  = sync_q[SYNC_STAGES-1];
    assign armed   = (arm_q == ARM_DONE);
    assign out_bus = out_q;
    assign irq     = irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q   <= '0;
            edge_q   <= '0;
            irq_en_q <= '0;
            arm_q    <= '0;
            irq_q    <= 1'b0;
            for (int j = 0; j < N_OUT; j++) out_q[j] <= OUT_RESET;
        end else begin
            sync_q[0] <= in_bus;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q   <= in_val;
            edge_q   <= edge_d;
            irq_en_q <= irq_en_d;
            out_q    <= out_d;
            irq_q    <= irq_d;
            if (!armed) arm_q <= arm_q + ARM_W'(1);
        end
    end

    // Clear is applied before set so a fresh edge survives a same-cycle W1C.
    always_comb begin
        edge_d   = edge_q;
        out_d    = out_q;
        irq_en_d = irq_en_q;
        irq_d    = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (load && address == ADDR_W'(N_IN + i)) edge_d[i] = edge_d[i] & ~data;
            if (armed) edge_d[i] = edge_d[i] | (in_val[i] & ~prev_q[i]);
            irq_d = irq_d | (irq_en_q[i] & (|edge_q[i]));
        end
        for (int j = 0; j < N_OUT; j++) begin
            if (load && address == ADDR_W'(E + j)) out_d[j] = data;
        end
        if (load && address == ADDR_W'(IRQ_ADDR)) irq_en_d = data[N_IN-1:0];
    end

    always_comb begin
        q = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (address == ADDR_W'(i))        q = in_val[i];
            if (address == ADDR_W'(N_IN + i)) q = edge_q[i];
        end
        for (int j = 0; j < N_OUT; j++) begin
            if (address == ADDR_W'(E + j)) q = out_q[j];
        end
        if (address == ADDR_W'(IRQ_ADDR)) begin
            q = '0;
            q[N_IN-1:0] = irq_en_q;
        end
    end

endmodule

// File: tb/tb_io_bank.sv
// Bench for io_bank: directed scenarios with literal expectations plus random
// traffic checked every cycle against a behavioural model of the register map.
module tb_io_bank;

    localparam int W  = 16;
    localparam int NI = 2;
    localparam int NO = 3;
    localparam int S  = 2;
    localparam int AW = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [AW-1:0]    address = '0;
    logic             load = 1'b0;
    logic [W-1:0]     data = '0;
    logic [W-1:0]     q;
    logic [NI*W-1:0]  in_bus = '0;
    logic [NO*W-1:0]  out_bus;
    logic             irq;

    int n_checks = 0;
    int n_fail   = 0;

    io_bank #(.WIDTH(W), .N_IN(NI), .N_OUT(NO), .SYNC_STAGES(S), .ADDR_W(AW), .OUT_RESET('0)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .load(load), .data(data),
        .q(q), .in_bus(in_bus), .out_bus(out_bus), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: input history queue, per-register arrays.
    logic [NI*W-1:0] hist[$];
    logic [NI*W-1:0] old_s;
    logic [W-1:0]    m_in[NI], m_prev[NI], m_edge[NI], m_out[NO], clr;
    logic [NI-1:0]   m_en;
    logic            m_irq, m_armed, irq_n;
    int              seen;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            for (int i = 0; i < NI; i++) begin m_in[i] = '0; m_prev[i] = '0; m_edge[i] = '0; end
            for (int j = 0; j < NO; j++) m_out[j] = '0;
            m_en = '0; m_irq = 1'b0; seen = 0;
        end else begin
            m_armed = (seen >= S + 1);
            irq_n = 1'b0;
            for (int i = 0; i < NI; i++) if (m_en[i] && m_edge[i] != 0) irq_n = 1'b1;
            hist.push_back(in_bus);
            if (hist.size() > S) void'(hist.pop_front());
            old_s = (hist.size() == S) ? hist[0] : '0;
            for (int i = 0; i < NI; i++) begin
                clr = (load && int'(address) == NI + i) ? data : '0;
                m_edge[i] = (m_edge[i] & ~clr) | (m_armed ? (m_in[i] & ~m_prev[i]) : '0);
                m_prev[i] = m_in[i];
                m_in[i]   = old_s[i*W +: W];
            end
            if (load && int'(address) >= 2*NI && int'(address) < 2*NI + NO) m_out[int'(address) - 2*NI] = data;
            if (load && int'(address) == 2*NI + NO) m_en = data[NI-1:0];
            m_irq = irq_n;
            if (seen < 1000) seen++;
        end
    end

    function automatic logic [W-1:0] exp_q(input int a);
        logic [W-1:0] r;
        r = '0;
        if (a < NI)                       r = m_in[a];
        else if (a < 2*NI)                r = m_edge[a - NI];
        else if (a < 2*NI + NO)           r = m_out[a - 2*NI];
        else if (a == 2*NI + NO)          r[NI-1:0] = m_en;
        return r;
    endfunction

    always @(negedge clk) begin
        chk("q_model", q, exp_q(int'(address)));
        chk("out_bus_model", out_bus, {m_out[2], m_out[1], m_out[0]});
        chk("irq_model", irq, m_irq);
    end

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [W-1:0] v);
        address = a;
        #1;
        v = q;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        address = a; data = d; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] v;
        logic [NI*W-1:0] t;

        // 1: reset with inputs already high
        in_bus = 32'hFFFF_0001;
        step(3);
        rd(0, v); chk("reset_in0", v, 16'h0000);
        chk("reset_out_bus", out_bus, 48'h0);
        chk("reset_irq", irq, 1'b0);
        rst_n = 1'b1;
        step();
        rd(0, v); chk("in0_after_1_edge", v, 16'h0000);
        step();
        rd(0, v); chk("in0_after_2_edges", v, 16'h0001);
        rd(1, v); chk("in1_after_2_edges", v, 16'hFFFF);
        for (int k = 0; k < 10; k++) begin
            rd(2, v); chk("edge0_unarmed", v, 16'h0000);
            rd(3, v); chk("edge1_unarmed", v, 16'h0000);
            step();
        end
        chk("irq_after_arm", irq, 1'b0);

        // 2: output writes and unmapped offset
        wr(4, 16'hBEEF);
        wr(6, 16'h1234);
        wr(9, 16'h5555);
        chk("out_bus_writes", out_bus, 48'h1234_0000_BEEF);
        rd(9, v); chk("unmapped_read", v, 16'h0000);
        rd(4, v); chk("out0_read", v, 16'hBEEF);

        // 3: rising edge, interrupt, W1C
        wr(7, 16'h0001);
        rd(2, v);
        in_bus = 32'hFFFF_0009;
        step(2);
        rd(2, v); chk("edge0_not_yet", v, 16'h0000);
        step();
        rd(2, v); chk("edge0_set", v, 16'h0008);
        chk("irq_not_yet", irq, 1'b0);
        step();
        chk("irq_rise", irq, 1'b1);
        wr(2, 16'h0008);
        rd(2, v); chk("edge0_cleared", v, 16'h0000);
        chk("irq_still_high", irq, 1'b1);
        step();
        chk("irq_dropped", irq, 1'b0);

        // 4: set beats same-cycle clear
        in_bus = 32'hFFFF_0001;
        step(4);
        rd(2, v); chk("edge0_no_fall_flag", v, 16'h0000);
        in_bus = 32'hFFFF_0009;
        step(2);
        address = 2; data = 16'h0008; load = 1'b1;
        step();
        load = 1'b0;
        rd(2, v); chk("set_wins_w1c", v, 16'h0008);

        // 5: interrupt mask
        wr(7, 16'h0002);
        step(2);
        chk("irq_masked", irq, 1'b0);
        rd(3, v); chk("edge1_clear", v, 16'h0000);
        wr(7, 16'h0003);
        chk("irq_en_write_edge", irq, 1'b0);
        step();
        chk("irq_unmasked", irq, 1'b1);
        rd(7, v); chk("irq_en_read", v, 16'h0003);

        // random traffic checked by the model
        for (int k = 0; k < 2000; k++) begin
            t = in_bus;
            for (int c = 0; c < NI; c++)
                if ($urandom_range(0, 2) == 0) t[c*W + int'($urandom_range(0, W-1))] ^= 1'b1;
            in_bus  = t;
            load    = ($urandom_range(0, 2) == 0);
            address = AW'($urandom_range(0, 15));
            data    = ($urandom_range(0, 1) == 0) ? W'($urandom) : (W'(1) << $urandom_range(0, W-1));
            step();
        end
        load = 1'b0;

        // 6: reset mid-operation
        in_bus = 32'hFFFF_0000;
        step(4);
        wr(4, 16'hBEEF);
        wr(7, 16'h0001);
        wr(2, 16'hFFFF);
        wr(3, 16'hFFFF);
        step();
        in_bus = 32'hFFFF_0100;
        step(3);
        rd(2, v); chk("edge0_pre_reset", v, 16'h0100);
        step();
        chk("irq_pre_reset", irq, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midreset_out_bus", out_bus, 48'h0);
        chk("midreset_irq", irq, 1'b0);
        rd(2, v); chk("midreset_edge0", v, 16'h0000);
        step(2);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            rd(2, v); chk("rearm_edge0", v, 16'h0000);
            rd(3, v); chk("rearm_edge1", v, 16'h0000);
            step();
        end
        rd(0, v); chk("rearm_in0", v, 16'h0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
